// File: rtl/viterbi_chan_pkg.sv
// Shared definitions for the channel test sequencer: run states, noise LFSR taps and defaults.
package viterbi_chan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DPRST,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // x^8+x^6+x^5+x^4+1 as feedback taps on state bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] DEFAULT_LFSR_SEED = 8'hA5;
  localparam int         DEFAULT_ERR_W     = 16;
  localparam int         DPRST_CYCLES      = 2;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/noise_lfsr8.sv
// 8-bit Fibonacci LFSR supplying the noise word; seed is loaded on reset or on load.
module noise_lfsr8
  import viterbi_chan_pkg::*;
(
  input  logic       clock,
  input  logic       rset,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  logic [7:0] lfsr_reg;

  always_ff @(posedge clock) begin
    if (rset || load) begin
      lfsr_reg <= seed;
    end else if (enable) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign state = lfsr_reg;

endmodule

// File: rtl/channel_test_sequencer.sv
// Run controller for encoder -> noisy channel -> Viterbi decoder; counts decoded bit errors.
// Define CHAN_ERR_CNT_EN to build the corrupted-channel-symbol counter (chan_errs), else it reads 0.
module channel_test_sequencer
  import viterbi_chan_pkg::*;
#(
  parameter int         CNT_W       = 9,
  parameter int         DEC_LATENCY = 18,
  parameter logic [7:0] LFSR_SEED   = DEFAULT_LFSR_SEED,
  parameter int         ERR_W       = DEFAULT_ERR_W
) (
  input  logic             clock,
  input  logic             rset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_bits,
  input  logic [7:0]       err_level_in,
  input  logic             src_valid,
  input  logic             src_bit,
  output logic             src_ready,
  output logic             tx_bit,
  output logic [7:0]       noise_e,
  output logic [7:0]       error_level,
  output logic             dp_rset,
  input  logic             dec_bit,
  input  logic [1:0]       chan_c,
  input  logic [1:0]       chan_cx,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] bit_errs,
  output logic [ERR_W-1:0] chan_errs
);

  state_t state_reg, state_next;
  logic [CNT_W-1:0]       num_bits_reg, bit_cnt_reg;
  logic [7:0]             err_level_reg;
  logic [1:0]             dprst_cnt_reg;
  logic [ERR_W-1:0]       bit_errs_reg;
  logic [DEC_LATENCY-1:0] dl_tag_reg, dl_bit_reg, tag_shift, bit_shift;
  logic [7:0]             lfsr_state;
  logic run_start, run_empty, accept, shifting, tags_pending, bit_err;

  always_ff @(posedge clock) begin
    if (rset) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    run_start  = 1'b0;
    run_empty  = 1'b0;
    src_ready  = 1'b0;
    tx_bit     = 1'b0;
    dp_rset    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    shifting   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        dp_rset = (state_reg == ST_IDLE);
        done    = (state_reg == ST_DONE);
        if (start) begin
          if (num_bits != '0) begin
            run_start  = 1'b1;
            state_next = ST_DPRST;
          end else begin
            run_empty  = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_DPRST: begin
        dp_rset = 1'b1;
        busy    = 1'b1;
        if (dprst_cnt_reg == 2'(DPRST_CYCLES - 1)) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        busy      = 1'b1;
        src_ready = 1'b1;
        shifting  = 1'b1;
        tx_bit    = src_valid & src_bit;
        if (src_valid && bit_cnt_reg == num_bits_reg - CNT_W'(1)) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy     = 1'b1;
        shifting = 1'b1;
        if (!tags_pending) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      run_start  = 1'b0;
      run_empty  = 1'b0;
    end
  end

  assign accept = src_ready & src_valid;

  // Tagged delay line: slot 0 takes this cycle's push, the last slot meets dec_bit.
  for (genvar gi = 0; gi < DEC_LATENCY; gi++) begin : g_dl
    if (gi == 0) begin : g_head
      assign tag_shift[gi] = accept;
      assign bit_shift[gi] = tx_bit;
    end else begin : g_body
      assign tag_shift[gi] = dl_tag_reg[gi-1];
      assign bit_shift[gi] = dl_bit_reg[gi-1];
    end
  end

  always_ff @(posedge clock) begin
    if (rset || run_start) begin
      dl_tag_reg <= '0;
      dl_bit_reg <= '0;
    end else if (shifting) begin
      dl_tag_reg <= tag_shift;
      dl_bit_reg <= bit_shift;
    end
  end

  // Tags that will still be in the line after this cycle's shift.
  always_comb begin
    tags_pending = 1'b0;
    for (int i = 0; i < DEC_LATENCY - 1; i++) tags_pending = tags_pending | dl_tag_reg[i];
  end

  assign bit_err = shifting & dl_tag_reg[DEC_LATENCY-1] & (dl_bit_reg[DEC_LATENCY-1] ^ dec_bit);

  always_ff @(posedge clock) begin
    if (rset) begin
      num_bits_reg  <= '0;
      bit_cnt_reg   <= '0;
      err_level_reg <= '0;
      dprst_cnt_reg <= '0;
      bit_errs_reg  <= '0;
    end else if (run_start) begin
      num_bits_reg  <= num_bits;
      err_level_reg <= err_level_in;
      bit_cnt_reg   <= '0;
      dprst_cnt_reg <= '0;
      bit_errs_reg  <= '0;
    end else if (run_empty) begin
      bit_cnt_reg  <= '0;
      bit_errs_reg <= '0;
    end else if (!abort) begin
      if (state_reg == ST_DPRST) dprst_cnt_reg <= dprst_cnt_reg + 2'd1;
      if (accept) bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
      if (bit_err && !(&bit_errs_reg)) bit_errs_reg <= bit_errs_reg + ERR_W'(1);
    end
  end

  noise_lfsr8 u_noise (
    .clock  (clock),
    .rset   (rset),
    .load   (run_start),
    .enable (shifting),
    .seed   (LFSR_SEED),
    .state  (lfsr_state)
  );

  assign noise_e     = shifting ? lfsr_state : 8'h00;
  assign error_level = err_level_reg;
  assign bit_errs    = bit_errs_reg;

`ifdef CHAN_ERR_CNT_EN
  logic [ERR_W-1:0] chan_errs_reg;
  logic [1:0]       sym_diff, sym_pop;
  logic [ERR_W:0]   chan_sum;

  assign sym_diff = chan_c ^ chan_cx;
  assign sym_pop  = {1'b0, sym_diff[0]} + {1'b0, sym_diff[1]};
  assign chan_sum = {1'b0, chan_errs_reg} + (ERR_W+1)'(sym_pop);

  always_ff @(posedge clock) begin
    if (rset || run_start || run_empty) begin
      chan_errs_reg <= '0;
    end else if (shifting && !abort) begin
      chan_errs_reg <= chan_sum[ERR_W] ? '1 : chan_sum[ERR_W-1:0];
    end
  end

  assign chan_errs = chan_errs_reg;
`else
  logic unused_chan;
  assign unused_chan = ^{chan_c, chan_cx};
  assign chan_errs   = '0;
`endif

endmodule
